// File: rtl/datapath_seq.sv
// Command FIFO + issue sequencer feeding an N-bit add/sub datapath, with a
// registered valid/ready result port and an optional accumulator operand.

module datapath #(
    parameter int unsigned N = 16
) (
    input  logic [2:0]   i_opcode,
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    output logic [N-1:0] o_y,
    output logic         o_co
);
    localparam int unsigned SW = N + 1;

    logic [N-1:0]  w_m;
    logic [SW-1:0] w_sum;

    // Operand M: B or zero, optionally inverted; opcode[0] is the carry-in.
    always_comb begin
        w_m = i_opcode[2] ? '0 : i_b;
        if (i_opcode[1]) begin
            w_m = ~w_m;
        end
    end

    assign w_sum = {1'b0, i_a} + {1'b0, w_m} + SW'(i_opcode[0]);
    assign o_y   = w_sum[N-1:0];
    assign o_co  = w_sum[N];
endmodule

module datapath_seq #(
    parameter int unsigned N     = 16,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [2:0]                 in_opcode,
    input  logic                       in_acc,
    input  logic [N-1:0]               in_a,
    input  logic [N-1:0]               in_b,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [N-1:0]               out_y,
    output logic                       out_co,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef struct packed {
        logic [2:0]   opcode;
        logic         acc;
        logic [N-1:0] a;
        logic [N-1:0] b;
    } cmd_t;

    cmd_t          r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [N-1:0]  r_acc;
    logic          r_out_valid;
    logic [N-1:0]  r_out_y;
    logic          r_out_co;

    cmd_t          w_in_cmd;
    cmd_t          w_head;
    logic          w_push;
    logic          w_issue;
    logic [N-1:0]  w_op_a;
    logic [N-1:0]  w_dp_y;
    logic          w_dp_co;

    assign in_ready  = (r_count < CW'(DEPTH));
    assign count     = r_count;
    assign out_valid = r_out_valid;
    assign out_y     = r_out_y;
    assign out_co    = r_out_co;

    assign w_in_cmd = '{opcode: in_opcode, acc: in_acc, a: in_a, b: in_b};
    assign w_head   = r_mem[r_rd_ptr];
    assign w_push   = in_valid && in_ready;
    // Issue only when the result register is empty or being drained this cycle.
    assign w_issue  = (r_count != '0) && (!r_out_valid || out_ready);
    assign w_op_a   = w_head.acc ? r_acc : w_head.a;

    datapath #(.N(N)) u_datapath (
        .i_opcode (w_head.opcode),
        .i_a      (w_op_a),
        .i_b      (w_head.b),
        .o_y      (w_dp_y),
        .o_co     (w_dp_co)
    );

    // Command storage; stale entries are harmless because pointers reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_in_cmd;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_acc       <= '0;
            r_out_valid <= 1'b0;
            r_out_y     <= '0;
            r_out_co    <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_issue) begin
                r_rd_ptr    <= r_rd_ptr + AW'(1);
                r_out_valid <= 1'b1;
                r_out_y     <= w_dp_y;
                r_out_co    <= w_dp_co;
                r_acc       <= w_dp_y;
            end else if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end
            r_count <= r_count + CW'(w_push) - CW'(w_issue);
        end
    end
endmodule

// File: tb/tb_datapath_seq.sv
// Self-checking bench for datapath_seq (N=8, DEPTH=4): directed vectors plus
// a randomized stream checked against an in-order result scoreboard.

module tb_datapath_seq;
    localparam int unsigned N     = 8;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned CW    = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [2:0]    in_opcode = '0;
    logic          in_acc = 1'b0;
    logic [N-1:0]  in_a = '0;
    logic [N-1:0]  in_b = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [N-1:0]  out_y;
    logic          out_co;
    logic [CW-1:0] count;

    datapath_seq #(.N(N), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_opcode (in_opcode),
        .in_acc    (in_acc),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_y     (out_y),
        .out_co    (out_co),
        .count     (count)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int n_out    = 0;

    logic [N:0]   exp_q [$];
    logic [N-1:0] m_acc = '0;
    logic         stall_prev = 1'b0;
    logic [N-1:0] stall_y = '0;
    logic         stall_co = 1'b0;
    logic [N:0]   mon_e;
    logic [N-1:0] mon_a;

    typedef struct {
        logic [2:0]   op;
        logic         acc;
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [N-1:0] y;
        logic         co;
    } vec_t;

    vec_t tbl [13];

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d @%0t", name, act, req, $time);
        end
    endtask

    // Reference result as a plain unsigned (N+1)-bit sum per opcode.
    function automatic logic [N:0] ref_calc(input logic [2:0] op, input logic [N-1:0] a,
                                            input logic [N-1:0] b);
        int ua, ub, m, s;
        ua = int'(a);
        ub = int'(b);
        m  = 1 << N;
        case (op)
            3'd0: s = ua + ub;
            3'd1: s = ua + ub + 1;
            3'd2: s = ua + (m - 1 - ub);
            3'd3: s = ua + (m - ub);
            3'd4: s = ua;
            3'd5: s = ua + 1;
            3'd6: s = ua + (m - 1);
            default: s = ua + m;
        endcase
        return (N+1)'(s);
    endfunction

    // Scoreboard: results come out in push order, so expected values
    // (including the accumulator chain) are computed at acceptance time.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            m_acc      = '0;
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check("stall_valid", int'(out_valid), 1);
                check("stall_y", int'(out_y), int'(stall_y));
                check("stall_co", int'(out_co), int'(stall_co));
            end
            stall_prev = out_valid && !out_ready;
            stall_y    = out_y;
            stall_co   = out_co;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL spurious_out actual=y%0d required=no_result @%0t", out_y, $time);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("sb_y", int'(out_y), int'(mon_e[N-1:0]));
                    check("sb_co", int'(out_co), int'(mon_e[N]));
                    n_out++;
                end
            end
            if (in_valid && in_ready) begin
                mon_a = in_acc ? m_acc : in_a;
                mon_e = ref_calc(in_opcode, mon_a, in_b);
                exp_q.push_back(mon_e);
                m_acc = mon_e[N-1:0];
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] op, input logic acc,
                         input logic [N-1:0] a, input logic [N-1:0] b);
        in_valid  = v;
        in_opcode = op;
        in_acc    = acc;
        in_a      = a;
        in_b      = b;
    endtask

    task automatic drain(input string name);
        int k;
        k = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while ((count != '0 || out_valid) && k < 40) begin
            tick();
            k++;
        end
        check({name, "_drained"}, int'(count == '0 && !out_valid), 1);
        check({name, "_sb_empty"}, exp_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        tbl[0]  = '{3'd0, 1'b0, 8'd100, 8'd27, 8'd127, 1'b0};
        tbl[1]  = '{3'd1, 1'b0, 8'd100, 8'd27, 8'd128, 1'b0};
        tbl[2]  = '{3'd2, 1'b0, 8'd100, 8'd27, 8'd72,  1'b1};
        tbl[3]  = '{3'd3, 1'b0, 8'd100, 8'd27, 8'd73,  1'b1};
        tbl[4]  = '{3'd4, 1'b0, 8'd100, 8'd27, 8'd100, 1'b0};
        tbl[5]  = '{3'd5, 1'b0, 8'd100, 8'd27, 8'd101, 1'b0};
        tbl[6]  = '{3'd6, 1'b0, 8'd100, 8'd27, 8'd99,  1'b1};
        tbl[7]  = '{3'd7, 1'b0, 8'd100, 8'd27, 8'd100, 1'b1};
        tbl[8]  = '{3'd0, 1'b0, 8'd5,   8'd3,  8'd8,   1'b0};
        tbl[9]  = '{3'd0, 1'b1, 8'd200, 8'd1,  8'd9,   1'b0};
        tbl[10] = '{3'd0, 1'b1, 8'd201, 8'd1,  8'd10,  1'b0};
        tbl[11] = '{3'd0, 1'b1, 8'd202, 8'd1,  8'd11,  1'b0};
        tbl[12] = '{3'd4, 1'b1, 8'd203, 8'd9,  8'd11,  1'b0};

        // Reset state
        tick();
        tick();
        check("rst_count", int'(count), 0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_y", int'(out_y), 0);
        check("rst_out_co", int'(out_co), 0);
        check("rst_in_ready", int'(in_ready), 1);
        rst = 1'b0;

        // Opcode sweep and accumulate chain, streamed back-to-back
        out_ready = 1'b1;
        for (int i = 0; i < 13; i++) begin
            drive(1'b1, tbl[i].op, tbl[i].acc, tbl[i].a, tbl[i].b);
            tick();
            check("stream_count", int'(count), 1);
            if (i == 0) begin
                check("first_latency", int'(out_valid), 0);
            end else begin
                check("vec_valid", int'(out_valid), 1);
                check("vec_y", int'(out_y), int'(tbl[i-1].y));
                check("vec_co", int'(out_co), int'(tbl[i-1].co));
            end
        end
        in_valid = 1'b0;
        tick();
        check("vec_last_valid", int'(out_valid), 1);
        check("vec_last_y", int'(out_y), int'(tbl[12].y));
        tick();
        check("out_drop", int'(out_valid), 0);

        // Backpressure until full
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 3'd0, 1'b0, 8'(10*i + 1), 8'd1);
            tick();
        end
        check("bp_count", int'(count), 4);
        check("bp_in_ready", int'(in_ready), 0);
        check("bp_out_valid", int'(out_valid), 1);
        check("bp_out_y", int'(out_y), 2);
        n0 = n_out;
        drain("bp");
        check("bp_results", n_out - n0, 5);

        // Simultaneous push and pop at count=2
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 3'd1, 1'b0, 8'(3*i), 8'(7*i));
            tick();
        end
        check("sim_pre_count", int'(count), 2);
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 3'(i), 1'(i & 1), 8'(17*i + 5), 8'(11*i));
            tick();
            check("sim_count", int'(count), 2);
        end
        drain("sim");

        // Reset with queued commands and a pending result
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 3'd0, 1'b0, 8'(i + 40), 8'd2);
            tick();
        end
        check("mid_pre_count", int'(count), 3);
        check("mid_pre_valid", int'(out_valid), 1);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        rst       = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_count", int'(count), 0);
        check("mid_out_valid", int'(out_valid), 0);
        check("mid_out_y", int'(out_y), 0);
        check("mid_out_co", int'(out_co), 0);
        check("mid_in_ready", int'(in_ready), 1);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("mid_no_ghost", int'(out_valid), 0);
        end
        drive(1'b1, 3'd4, 1'b1, 8'd77, 8'd5);
        tick();
        in_valid = 1'b0;
        tick();
        check("acc_reset_valid", int'(out_valid), 1);
        check("acc_reset_y", int'(out_y), 0);
        drain("mid");

        // Randomized stream with output stalls (pointers wrap many times)
        for (int i = 0; i < 300; i++) begin
            drive(1'($urandom_range(0, 1)), 3'($urandom), 1'($urandom), 8'($urandom), 8'($urandom));
            out_ready = ($urandom_range(0, 9) < 7);
            tick();
            check("rand_ready", int'(in_ready), int'(count < CW'(DEPTH)));
            check("rand_count_max", int'(count <= CW'(DEPTH)), 1);
        end
        drain("rand");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/datapath_seq.md
# datapath_seq

Command-driven sequencer and result buffer for the arithmetic `datapath` block. It accepts operation commands (opcode plus two signed N-bit operands) through a valid/ready handshake and queues them in a DEPTH-entry FIFO. It issues at most one command per cycle to an internal `datapath` instance and returns each result (Y, carry-out) through a registered valid/ready output. An accumulate mode chains operations by substituting the previous result for operand A.

## Interface
- N, 16, operand/result width in bits (≥2)
- DEPTH, 4, command FIFO entries (power of two, ≥2)

- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  command present
- in_ready  output  1  FIFO can accept a command
- in_opcode  input  3  datapath opcode
- in_acc  input  1  1 = use accumulator instead of in_a as operand A
- in_a  input  N  signed operand A
- in_b  input  N  signed operand B
- out_valid  output  1  result register holds an unconsumed result
- out_ready  input  1  consumer takes result
- out_y  output  N  signed result
- out_co  output  1  carry-out of the N-bit add
- count  output  $clog2(DEPTH)+1  FIFO occupancy

Clock and reset: one clock (`clk`); reset (`rst`) is synchronous and active-high.

## Operation
- Opcode semantics (Y = A + M + opcode[0], {co,Y} is the N+1-bit sum):
  - M = opcode[2] ? 0 : B, then inverted if opcode[1].
  - 000 A+B; 001 A+B+1; 010 A+~B; 011 A−B; 100 A; 101 A+1; 110 A−1; 111 A with co=1.
- Push: in_valid && in_ready writes {opcode, acc, a, b} at the write pointer.
- in_ready = (count < DEPTH). It is low when the FIFO is full, even if a pop happens in the same cycle; no full-bypass.
- Issue condition: count > 0 && (!out_valid || out_ready).
- On issue:
  - Pop the head entry.
  - Operand A = head.acc ? acc_reg : head.a.
  - Load out_y/out_co from the datapath output and set out_valid = 1.
  - acc_reg ← Y.
- No issue but out_valid && out_ready: out_valid ← 0.
- Simultaneous push and issue: count is unchanged and both pointers advance.
- Pointers wrap modulo DEPTH.
- Accumulator:
  - Updated only on issue.
  - Accumulate commands see the result of the immediately preceding issued command, including when back-to-back.
  - Holds its value when no command issues.
- Reset values (rst high at a clock edge):
  - count = 0, pointers = 0, acc_reg = 0.
  - out_valid = 0, out_y = 0, out_co = 0.
  - in_ready = 1 from the cycle after reset.
- Reset mid-operation discards all queued commands and any pending result; no output handshake completes in the reset cycle.
- Width rules:
  - All arithmetic is N bits, two's complement, wrap-around.
  - out_co is the raw bit N of the unsigned sum. It is not a signed overflow flag.

## Timing
- Minimum latency:
  - Command accepted at edge t.
  - Issued at edge t+1 if the FIFO was empty and the output was free.
  - out_valid is high in the cycle after edge t+1.
- Throughput: one command per cycle when out_ready is held high.
- Backpressure:
  - While out_valid && !out_ready: out_y, out_co and out_valid are held stable and nothing issues.
  - The FIFO fills; in_ready drops when count reaches DEPTH.
- in_ready and count are registered-state functions only, with no combinational path from in_valid.
- out_valid, out_y and out_co are registers.
- No combinational path from out_ready to out_valid.
- Zero-cycle bypass from input to output is not allowed.

## Test plan
- **Reset:** assert rst with FIFO holding 3 commands and out_valid=1 → next cycle count=0, out_valid=0, out_y=0, in_ready=1; the queued commands never appear.
- **Opcode sweep (N=8):** push A=8'sd100, B=8'sd27 with opcodes 000…111, out_ready=1 → Y/co =
  - 000: 127/0
  - 001: 128 (−128)/0
  - 010: 72/1
  - 011: 73/1
  - 100: 100/0
  - 101: 101/0
  - 110: 99/1
  - 111: 100/1
  - Results arrive one per cycle, in order, first result one cycle after its push.
- **Accumulate chain:**
  - Push (000, acc=0, A=5, B=3) then three commands (000, acc=1, B=1) back-to-back.
  - Required outputs: 8, 9, 10, 11.
  - A fifth command (100, acc=1) returns 11.
- **Backpressure/full (DEPTH=4):**
  - Hold out_ready=0 and push 6 commands → the first result is held stable, 4 commands are queued, and in_ready=0 with count=4.
  - Release out_ready → all 5 results drain in order with no loss or duplication.
- **Simultaneous push/pop:** at count=2 with continuous push and out_ready=1 → count stays 2 and results stay in order.
- **Wrap-around:** stream 3×DEPTH+1 commands with random out_ready stalls → results match a scoreboard model bit-exactly and the pointers wrap correctly.
